// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: hazard / flush controller with a 2-bit saturating branch
// predictor. Detects load-use and branch-mispredict hazards and drives the
// PC / IF-ID write enables, the IF-ID / ID-EX flushes and the active-low
// decoder bubble (ctrl_flush).
// Optional feature macro: BRPRED_STATS_EN adds saturating br_cnt and
// mispred_cnt statistics outputs of width CNT_W.
module hazard_flush_ctrl #(
  parameter logic [1:0]  PRED_INIT = 2'b01,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_mem,
  input  logic [1:0]       id_branch,
  input  logic             id_jump,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_valid,
  input  logic             ex_branch_taken,
  input  logic             ex_pred_taken,
  output logic             pred_taken,
  output logic             ctrl_flush,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush
`ifdef BRPRED_STATS_EN
  ,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
`endif
);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_e;

  pred_e pstate;
  pred_e pstate_next;
  logic  update;
  logic  mispred;
  logic  lduse;

  // A resolved branch trains the predictor only when the pipe is not frozen.
  assign update  = ex_branch_valid & ~stall_mem;
  assign mispred = ex_branch_valid & (ex_branch_taken ^ ex_pred_taken);
  assign lduse   = ex_memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Prediction uses the registered state; a same-cycle update is not bypassed.
  assign pred_taken = pstate[1] & (id_branch != 2'b00);

  // Predictor state register.
  always_ff @(posedge clk) begin
    if (rst) pstate <= pred_e'(PRED_INIT);
    else     pstate <= pstate_next;
  end

  // Predictor next state: saturating up on taken, down on not taken.
  always_comb begin
    pstate_next = pstate;
    if (update) begin
      if (ex_branch_taken) begin
        unique case (pstate)
          SNT: pstate_next = WNT;
          WNT: pstate_next = WT;
          WT:  pstate_next = ST;
          ST:  pstate_next = ST;
        endcase
      end else begin
        unique case (pstate)
          SNT: pstate_next = SNT;
          WNT: pstate_next = SNT;
          WT:  pstate_next = WNT;
          ST:  pstate_next = WT;
        endcase
      end
    end
  end

  // Output priority: reset, memory stall, mispredict, load-use, redirect, normal.
  always_comb begin
    ctrl_flush = 1'b1;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      ctrl_flush = 1'b0;
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall_mem) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (mispred) begin
      ctrl_flush = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lduse) begin
      ctrl_flush = 1'b0;
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
    end else if (id_jump | pred_taken) begin
      ifid_flush = 1'b1;
    end
  end

`ifdef BRPRED_STATS_EN
  // Statistics counters: saturate at all-ones, frozen by stall_mem.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (update) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if (mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural model of the predictor
// and the output priority rules.
module tb_hazard_flush_ctrl;

  localparam int CNT_MAX = 3;  // CNT_W = 2

  logic       clk = 1'b0;
  logic       rst;
  logic       stall_mem;
  logic [1:0] id_branch;
  logic       id_jump;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, ex_branch_valid, ex_branch_taken, ex_pred_taken;
  logic       pred_taken, ctrl_flush, pc_we, ifid_we, ifid_flush, idex_flush;
`ifdef BRPRED_STATS_EN
  logic [1:0] br_cnt, mispred_cnt;
`endif

  logic [5:0] got;
  assign got = {pred_taken, ctrl_flush, pc_we, ifid_we, ifid_flush, idex_flush};

  int checks = 0;
  int errors = 0;
  int mstate;           // predictor strength 0..3
  int mbr, mmis;        // statistics model

  hazard_flush_ctrl #(.PRED_INIT(2'b01), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .id_branch(id_branch),
    .id_jump(id_jump), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_branch_valid(ex_branch_valid),
    .ex_branch_taken(ex_branch_taken), .ex_pred_taken(ex_pred_taken),
    .pred_taken(pred_taken), .ctrl_flush(ctrl_flush), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush)
`ifdef BRPRED_STATS_EN
    , .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected {pred_taken, ctrl_flush, pc_we, ifid_we, ifid_flush, idex_flush}
  function automatic logic [5:0] expv();
    logic p, mis, lu;
    p   = (mstate >= 2) && (id_branch != 2'b00);
    mis = ex_branch_valid && (ex_branch_taken != ex_pred_taken);
    lu  = ex_memread && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    if (rst)                 return {p, 5'b00011};
    else if (stall_mem)      return {p, 5'b10000};
    else if (mis)            return {p, 5'b01111};
    else if (lu)             return {p, 5'b00000};
    else if (id_jump || p)   return {p, 5'b11110};
    else                     return {p, 5'b11100};
  endfunction

  task automatic drive(input logic r, input logic st, input logic [1:0] br,
                       input logic j, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] ert, input logic v,
                       input logic t, input logic pt);
    rst = r; stall_mem = st; id_branch = br; id_jump = j; id_rs = rs; id_rt = rt;
    ex_memread = mr; ex_rt = ert; ex_branch_valid = v; ex_branch_taken = t;
    ex_pred_taken = pt;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mstate = 1; mbr = 0; mmis = 0;
    end else if (ex_branch_valid && !stall_mem) begin
      mstate = ex_branch_taken ? ((mstate < 3) ? mstate + 1 : 3)
                               : ((mstate > 0) ? mstate - 1 : 0);
      if (mbr < CNT_MAX) mbr++;
      if ((ex_branch_taken != ex_pred_taken) && (mmis < CNT_MAX)) mmis++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    #1; checks++;
    if (got !== expv()) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", got, expv());
    end
    drive(0, 0, 2'b01, 0, 1, 2, 0, 0, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b011100) begin
      errors++; $display("FAIL reset_pred_init got=%b exp=%b", got, 6'b011100);
    end
    tick();
  endtask

  task automatic test_predictor();
    // three taken updates: 01 -> 10 -> 11 -> 11; pred visible on id_branch=01
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2'b01, 0, 1, 2, 0, 0, 1, 1, 1);
      tick();
      drive(0, 0, 2'b01, 0, 1, 2, 0, 0, 0, 0, 0);
      #1; checks++;
      if (pred_taken !== 1'b1 || got !== expv()) begin
        errors++; $display("FAIL pred_up%0d got=%b exp=%b", i, got, expv());
      end
    end
    // four not-taken: 11 -> 10 (still taken) -> 01 -> 00 -> 00
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 2'b10, 0, 1, 2, 0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 2'b10, 0, 1, 2, 0, 0, 0, 0, 0);
      #1; checks++;
      if (pred_taken !== ((i == 0) ? 1'b1 : 1'b0) || got !== expv()) begin
        errors++; $display("FAIL pred_down%0d got=%b exp=%b", i, got, expv());
      end
    end
    // id_branch none never predicts
    drive(0, 0, 2'b00, 0, 1, 2, 0, 0, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b011100) begin
      errors++; $display("FAIL pred_nobranch got=%b exp=%b", got, 6'b011100);
    end
  endtask

  task automatic test_lduse();
    drive(0, 0, 2'b00, 0, 5, 7, 1, 5, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b000000) begin
      errors++; $display("FAIL lduse_stall got=%b exp=%b", got, 6'b000000);
    end
    tick();
    // bubble clears ex_memread: stall lasts one cycle
    drive(0, 0, 2'b00, 0, 5, 7, 0, 0, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b011100) begin
      errors++; $display("FAIL lduse_release got=%b exp=%b", got, 6'b011100);
    end
    tick();
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b011100) begin
      errors++; $display("FAIL lduse_r0 got=%b exp=%b", got, 6'b011100);
    end
    drive(0, 0, 2'b00, 0, 3, 9, 1, 9, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b000000) begin
      errors++; $display("FAIL lduse_rt got=%b exp=%b", got, 6'b000000);
    end
    tick();
  endtask

  task automatic test_mispred();
    // mispredict with load-use also present: mispredict wins
    drive(0, 0, 2'b00, 0, 5, 7, 1, 5, 1, 1, 0);
    #1; checks++;
    if (got !== 6'b001111) begin
      errors++; $display("FAIL mispred got=%b exp=%b", got, 6'b001111);
    end
    tick();
    drive(0, 0, 2'b00, 0, 5, 7, 0, 0, 0, 0, 0);
    #1; checks++;
    if (got !== expv()) begin
      errors++; $display("FAIL mispred_after got=%b exp=%b", got, expv());
    end
  endtask

  task automatic test_stall_mem();
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // predictor at 01; stall with a taken mispredict must not train it
    drive(0, 1, 2'b01, 0, 5, 7, 1, 5, 1, 1, 0);
    #1; checks++;
    if (got !== 6'b010000) begin
      errors++; $display("FAIL stall_mem got=%b exp=%b", got, 6'b010000);
    end
    tick();
    drive(0, 0, 2'b01, 0, 5, 7, 1, 5, 1, 1, 0);
    #1; checks++;
    if (got !== 6'b001111) begin
      errors++; $display("FAIL stall_release got=%b exp=%b", got, 6'b001111);
    end
    tick();
    // one real update from 01 -> 10
    drive(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b111110) begin
      errors++; $display("FAIL stall_pstate got=%b exp=%b", got, 6'b111110);
    end
    // reset mid-stall returns predictor to 01
    drive(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b011100) begin
      errors++; $display("FAIL stall_rst got=%b exp=%b", got, 6'b011100);
    end
    tick();
  endtask

  task automatic test_jump_and_reset();
    drive(0, 0, 2'b00, 1, 1, 2, 0, 0, 0, 0, 0);
    #1; checks++;
    if (got !== 6'b011110) begin
      errors++; $display("FAIL jump got=%b exp=%b", got, 6'b011110);
    end
    tick();
    drive(1, 0, 2'b00, 1, 1, 2, 0, 0, 0, 0, 0);
    tick();
    #1; checks++;
    if (got !== 6'b000011) begin
      errors++; $display("FAIL jump_rst got=%b exp=%b", got, 6'b000011);
    end
    drive(0, 0, 2'b00, 0, 1, 2, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 6) == 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
      #1; checks++;
      if (got !== expv()) begin
        errors++; $display("FAIL random%0d got=%b exp=%b", i, got, expv());
      end
      tick();
    end
  endtask

`ifdef BRPRED_STATS_EN
  task automatic test_stats();
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0);
      tick();
    end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; checks++;
    if (br_cnt !== 2'(mbr) || mispred_cnt !== 2'(mmis) || mbr != 3 || mmis != 3) begin
      errors++;
      $display("FAIL stats got=%0d/%0d exp=%0d/%0d", br_cnt, mispred_cnt, mbr, mmis);
    end
  endtask
`endif

  initial begin
    mstate = 1; mbr = 0; mmis = 0;
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_predictor();
    test_lduse();
    test_mispred();
    test_stall_mem();
    test_jump_and_reset();
    test_random();
`ifdef BRPRED_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
